// File: rtl/id_pipe_pkg.sv
// rtl/id_pipe_pkg.sv - shared opcodes, FSM states and immediate-type helpers for the ID stage
package id_pipe_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CALCI  = 7'b0010011;
  localparam logic [6:0] OP_CALC   = 7'b0110011;

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_HAZARD = 2'd2} state_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:            imm_type = IMM_U;
      OP_JAL:                      imm_type = IMM_J;
      OP_JALR, OP_LOAD, OP_CALCI:  imm_type = IMM_I;
      OP_BRANCH:                   imm_type = IMM_B;
      OP_STORE:                    imm_type = IMM_S;
      default:                     imm_type = IMM_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm32(input logic [31:0] inst);
    case (imm_type(inst[6:0]))
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    uses_rs1 = (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_CALCI) || (op == OP_CALC);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    uses_rs2 = (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_CALC);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    writes_rd = (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
                (op == OP_LOAD) || (op == OP_CALCI) || (op == OP_CALC);
  endfunction

  // Opcode and funct combinations that RV32I defines; anything else decodes as a NOP.
  function automatic logic funct_ok(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: funct_ok = 1'b1;
      OP_JALR:   funct_ok = (f3 == 3'b000);
      OP_BRANCH: funct_ok = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LOAD:   funct_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                            (f3 == 3'b100) || (f3 == 3'b101);
      OP_STORE:  funct_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OP_CALCI:  funct_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                            (f3 == 3'b101) ? ((f7 == 7'h00) || (f7 == 7'h20)) : 1'b1;
      OP_CALC:   funct_ok = (f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      default:   funct_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_pipe_fwd_sel.sv
// rtl/id_pipe_fwd_sel.sv - one-operand forwarding mux: youngest matching channel wins, flags load-use
module id_fwd_sel #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32
) (
  input  logic [4:0]              i_addr,
  input  logic [XLEN-1:0]         i_rf_data,
  input  logic [NUM_FWD-1:0]      i_fwd_valid,
  input  logic [5*NUM_FWD-1:0]    i_fwd_wd,
  input  logic [XLEN*NUM_FWD-1:0] i_fwd_wdata,
  input  logic [NUM_FWD-1:0]      i_fwd_is_load,
  output logic [XLEN-1:0]         o_data,
  output logic                    o_hazard
);

  // Scan oldest to youngest so the lowest-index match is the last assignment.
  always_comb begin
    o_data   = i_rf_data;
    o_hazard = 1'b0;
    if (i_addr == 5'd0) begin
      o_data = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (i_fwd_valid[i] && (i_fwd_wd[5*i +: 5] == i_addr)) begin
          o_data   = i_fwd_wdata[XLEN*i +: XLEN];
          o_hazard = i_fwd_is_load[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - RV32I decode stage with operand forwarding, load-use stall and registered bundle
module id_pipe #(
  parameter int NUM_FWD = 2,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_is_load_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [6:0]              opcode_o,
  output logic [2:0]              funct3_o,
  output logic                    funct7b5_o,
  output logic [XLEN-1:0]         rs1_data_o,
  output logic [XLEN-1:0]         rs2_data_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic                    branch_flag_o,
  output logic [XLEN-1:0]         jump_addr_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);
  import id_pipe_pkg::*;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic            w_ok, w_use1, w_use2, w_wreg;
  logic [XLEN-1:0] w_imm, w_pc4, w_fwd1, w_fwd2, w_src1, w_src2;
  logic            w_hz1, w_hz2, w_hazard, w_accept, w_taken;
  logic [XLEN-1:0] w_rs1_val, w_jaddr;
  logic            w_branch;

  assign w_op        = inst_i[6:0];
  assign w_f3        = inst_i[14:12];
  assign w_rd        = inst_i[11:7];
  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];
  assign w_ok        = funct_ok(inst_i);
  assign w_use1      = uses_rs1(w_op);
  assign w_use2      = uses_rs2(w_op);
  assign w_imm       = XLEN'($signed(imm32(inst_i)));
  assign w_pc4       = pc_i + XLEN'(4);
  assign w_wreg      = w_ok && writes_rd(w_op) && (w_rd != 5'd0);

  id_fwd_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd1 (
    .i_addr(reg1_addr_o), .i_rf_data(reg1_data_i), .i_fwd_valid(fwd_valid_i),
    .i_fwd_wd(fwd_wd_i), .i_fwd_wdata(fwd_wdata_i), .i_fwd_is_load(fwd_is_load_i),
    .o_data(w_fwd1), .o_hazard(w_hz1));

  id_fwd_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd2 (
    .i_addr(reg2_addr_o), .i_rf_data(reg2_data_i), .i_fwd_valid(fwd_valid_i),
    .i_fwd_wd(fwd_wd_i), .i_fwd_wdata(fwd_wdata_i), .i_fwd_is_load(fwd_is_load_i),
    .o_data(w_fwd2), .o_hazard(w_hz2));

  assign w_src1   = w_use1 ? w_fwd1 : '0;
  assign w_src2   = w_use2 ? w_fwd2 : '0;
  assign w_hazard = (w_use1 && w_hz1) || (w_use2 && w_hz2);

  assign in_ready_o = !rst && !w_hazard && (!out_valid_o || out_ready_i) && !flush_i;
  assign w_accept   = in_valid_i && in_ready_o;

  always_comb begin
    case (w_f3)
      3'b000:  w_taken = (w_src1 == w_src2);
      3'b001:  w_taken = (w_src1 != w_src2);
      3'b100:  w_taken = ($signed(w_src1) <  $signed(w_src2));
      3'b101:  w_taken = ($signed(w_src1) >= $signed(w_src2));
      3'b110:  w_taken = (w_src1 <  w_src2);
      3'b111:  w_taken = (w_src1 >= w_src2);
      default: w_taken = 1'b0;
    endcase
  end

  // rs1_data carries the link/result value for the ops that never read rs1.
  always_comb begin
    w_rs1_val = w_src1;
    w_branch  = 1'b0;
    w_jaddr   = w_pc4;
    case (w_op)
      OP_LUI:   w_rs1_val = w_imm;
      OP_AUIPC: w_rs1_val = pc_i + w_imm;
      OP_JAL: begin
        w_rs1_val = w_pc4;
        w_branch  = 1'b1;
        w_jaddr   = pc_i + w_imm;
      end
      OP_JALR: begin
        w_rs1_val = w_pc4;
        if (w_ok) begin
          w_branch = 1'b1;
          w_jaddr  = (w_src1 + w_imm) & ~XLEN'(1);
        end
      end
      OP_BRANCH: begin
        if (w_ok && w_taken) begin
          w_branch = 1'b1;
          w_jaddr  = pc_i + w_imm;
        end
      end
      default: ;
    endcase
  end

  state_e r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_EMPTY;
      out_valid_o   <= 1'b0;
      stall_cnt_o   <= '0;
      pc_o          <= '0;
      opcode_o      <= '0;
      funct3_o      <= '0;
      funct7b5_o    <= 1'b0;
      rs1_data_o    <= '0;
      rs2_data_o    <= '0;
      imm_o         <= '0;
      wd_o          <= '0;
      wreg_o        <= 1'b0;
      branch_flag_o <= 1'b0;
      jump_addr_o   <= '0;
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      out_valid_o <= 1'b0;
    end else begin
      if (r_state == ST_HAZARD && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (w_accept) begin
        r_state       <= ST_FULL;
        out_valid_o   <= 1'b1;
        pc_o          <= pc_i;
        opcode_o      <= w_op;
        funct3_o      <= w_f3;
        funct7b5_o    <= inst_i[30];
        rs1_data_o    <= w_rs1_val;
        rs2_data_o    <= w_src2;
        imm_o         <= w_imm;
        wd_o          <= w_wreg ? w_rd : 5'd0;
        wreg_o        <= w_wreg;
        branch_flag_o <= w_branch;
        jump_addr_o   <= w_jaddr;
      end else begin
        if (out_ready_i)
          out_valid_o <= 1'b0;
        if (in_valid_i && w_hazard)
          r_state <= ST_HAZARD;
        else
          r_state <= (out_valid_o && !out_ready_i) ? ST_FULL : ST_EMPTY;
      end
    end
  end

endmodule
